// File: rtl/except_pipe.sv
// except_pipe: carries exception packs ID->EX->MEM->WB, merges MEM faults, runs the WB trap handshake and flush
module except_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid_i,
  input  logic            id_except_i,
  input  logic [XLEN-1:0] id_epc_i,
  input  logic [XLEN-1:0] id_ecause_i,
  input  logic [XLEN-1:0] id_etval_i,
  input  logic            stall_i,
  input  logic            mem_except_i,
  input  logic [XLEN-1:0] mem_ecause_i,
  input  logic [XLEN-1:0] mem_etval_i,
  output logic            trap_req_o,
  output logic [XLEN-1:0] trap_epc_o,
  output logic [XLEN-1:0] trap_ecause_o,
  output logic [XLEN-1:0] trap_etval_o,
  input  logic            trap_ack_i,
  output logic            stall_o,
  output logic            flush_o
);
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;
  state_t state;
  logic e_v, e_x, m_v, m_x, w_v, w_x;
  logic [XLEN-1:0] e_epc, e_cause, e_tval, m_epc, m_cause, m_tval, w_epc, w_cause, w_tval;
  logic adv, mem_hit;
  logic [XLEN-1:0] mg_cause, mg_tval;
  assign adv = !stall_i && !stall_o;
  // an older decode-stage exception wins over a memory fault
  assign mem_hit  = m_v && !m_x && mem_except_i;
  assign mg_cause = mem_hit ? mem_ecause_i : m_cause;
  assign mg_tval  = mem_hit ? mem_etval_i : m_tval;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {e_v, e_x, m_v, m_x, w_v, w_x} <= '0;
      {e_epc, e_cause, e_tval} <= '0;
      {m_epc, m_cause, m_tval} <= '0;
      {w_epc, w_cause, w_tval} <= '0;
    end else if (flush_o) begin
      {e_v, e_x, m_v, m_x, w_v, w_x} <= '0;
    end else if (adv) begin
      {e_v, e_x, e_epc, e_cause, e_tval} <= {id_valid_i, id_except_i, id_epc_i, id_ecause_i, id_etval_i};
      {m_v, m_x, m_epc, m_cause, m_tval} <= {e_v, e_x, e_epc, e_cause, e_tval};
      {w_v, w_x, w_epc, w_cause, w_tval} <= {m_v, m_x | mem_hit, m_epc, mg_cause, mg_tval};
    end
  end
  // trap fields are captured on entry to REQ so they stay stable while W keeps moving for that one edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      {trap_req_o, stall_o, flush_o} <= '0;
      {trap_epc_o, trap_ecause_o, trap_etval_o} <= '0;
    end else begin
      case (state)
        IDLE: if (w_v && w_x) begin
          state <= REQ;
          {trap_req_o, stall_o} <= 2'b11;
          {trap_epc_o, trap_ecause_o, trap_etval_o} <= {w_epc, w_cause, w_tval};
        end
        REQ: if (trap_ack_i) begin
          state <= FLUSH;
          {trap_req_o, stall_o, flush_o} <= 3'b001;
          {trap_epc_o, trap_ecause_o, trap_etval_o} <= '0;
        end
        FLUSH: begin
          state   <= IDLE;
          flush_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
          {trap_req_o, stall_o, flush_o} <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_except_pipe.sv
// tb_except_pipe: directed vectors for except_pipe with hand-computed expectations
module tb_except_pipe;
  logic clk = 0, rstn = 0;
  logic id_valid_i = 0, id_except_i = 0, stall_i = 0, mem_except_i = 0, trap_ack_i = 0;
  logic [63:0] id_epc_i = 0, id_ecause_i = 0, id_etval_i = 0, mem_ecause_i = 0, mem_etval_i = 0;
  logic trap_req_o, stall_o, flush_o;
  logic [63:0] trap_epc_o, trap_ecause_o, trap_etval_o;
  int checks = 0, failures = 0;
  except_pipe #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid_i(id_valid_i), .id_except_i(id_except_i),
    .id_epc_i(id_epc_i), .id_ecause_i(id_ecause_i), .id_etval_i(id_etval_i),
    .stall_i(stall_i), .mem_except_i(mem_except_i),
    .mem_ecause_i(mem_ecause_i), .mem_etval_i(mem_etval_i),
    .trap_req_o(trap_req_o), .trap_epc_o(trap_epc_o),
    .trap_ecause_o(trap_ecause_o), .trap_etval_o(trap_etval_o),
    .trap_ack_i(trap_ack_i), .stall_o(stall_o), .flush_o(flush_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic v, input logic x, input logic [63:0] epc, input logic [63:0] cause, input logic [63:0] tval);
    {id_valid_i, id_except_i, id_epc_i, id_ecause_i, id_etval_i} = {v, x, epc, cause, tval};
  endtask
  task automatic ack_trap();
    trap_ack_i = 1;
    step();
    chk("ack_flush", flush_o, 1);
    chk("ack_req_drop", {trap_req_o, stall_o}, 0);
    trap_ack_i = 0;
    step();
    chk("flush_one_cycle", flush_o, 0);
  endtask
  task automatic drain();
    issue(0, 0, 0, 0, 0);
    repeat (4) step();
  endtask
  initial begin
    repeat (2) step();
    chk("rst_ctl", {trap_req_o, stall_o, flush_o}, 0);
    chk("rst_epc", trap_epc_o, 0);
    rstn = 1;
    step();
    // clean stream, with a stray ack that must be ignored outside REQ
    issue(1, 0, 64'h8000_0000, 0, 0);
    trap_ack_i = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("clean_ctl", {trap_req_o, stall_o, flush_o}, 0);
    end
    trap_ack_i = 0;
    drain();
    // illegal instruction from the examiner
    issue(1, 1, 64'h8000_0010, 2, 64'h1234);
    step();
    issue(1, 0, 64'h8000_0014, 0, 0);
    step();
    step();
    chk("ill_c3_req", trap_req_o, 0);
    step();
    chk("ill_req", trap_req_o, 1);
    chk("ill_stall", stall_o, 1);
    chk("ill_epc", trap_epc_o, 64'h8000_0010);
    chk("ill_cause", trap_ecause_o, 2);
    chk("ill_tval", trap_etval_o, 64'h1234);
    step();
    chk("ill_hold_req", trap_req_o, 1);
    chk("ill_hold_epc", trap_epc_o, 64'h8000_0010);
    step();
    chk("ill_c6_flush", flush_o, 0);
    ack_trap();
    chk("ill_c8_req", trap_req_o, 0);
    drain();
    chk("ill_no_retrap", trap_req_o, 0);
    // memory fault merged at MEM
    issue(1, 0, 64'h8000_0020, 0, 0);
    step();
    issue(0, 0, 0, 0, 0);
    step();
    {mem_except_i, mem_ecause_i, mem_etval_i} = {1'b1, 64'd4, 64'h8000_1001};
    step();
    mem_except_i = 0;
    step();
    chk("mem_req", trap_req_o, 1);
    chk("mem_epc", trap_epc_o, 64'h8000_0020);
    chk("mem_cause", trap_ecause_o, 4);
    chk("mem_tval", trap_etval_o, 64'h8000_1001);
    ack_trap();
    drain();
    // memory fault with nothing valid in M is ignored
    {mem_except_i, mem_ecause_i, mem_etval_i} = {1'b1, 64'd5, 64'h77};
    repeat (3) step();
    mem_except_i = 0;
    repeat (3) step();
    chk("mem_invalid_ignored", trap_req_o, 0);
    // decode exception outranks a memory fault on the same instruction
    issue(1, 1, 64'h8000_0030, 8, 0);
    step();
    issue(0, 0, 0, 0, 0);
    step();
    {mem_except_i, mem_ecause_i, mem_etval_i} = {1'b1, 64'd6, 64'hdead};
    step();
    mem_except_i = 0;
    step();
    chk("prio_req", trap_req_o, 1);
    chk("prio_epc", trap_epc_o, 64'h8000_0030);
    chk("prio_cause", trap_ecause_o, 8);
    chk("prio_tval", trap_etval_o, 0);
    ack_trap();
    drain();
    // stall while the exception sits in E, second exception one slot behind
    issue(1, 1, 64'h8000_0040, 2, 64'h40);
    step();
    issue(1, 1, 64'h8000_0044, 3, 64'h44);
    stall_i = 1;
    repeat (3) step();
    stall_i = 0;
    chk("stall_c4_req", trap_req_o, 0);
    step();
    issue(0, 0, 0, 0, 0);
    step();
    chk("stall_c6_req", trap_req_o, 0);
    step();
    chk("stall_req", trap_req_o, 1);
    chk("stall_epc", trap_epc_o, 64'h8000_0040);
    chk("stall_cause", trap_ecause_o, 2);
    stall_i = 1;
    step();
    stall_i = 0;
    chk("stall_hold_epc", trap_epc_o, 64'h8000_0040);
    chk("stall_hold_req", trap_req_o, 1);
    ack_trap();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("second_discarded", {trap_req_o, flush_o}, 0);
    end
    // reset in the middle of a handshake
    issue(1, 1, 64'h8000_0050, 2, 64'h50);
    step();
    issue(0, 0, 0, 0, 0);
    repeat (3) step();
    chk("rstreq_req", trap_req_o, 1);
    #2;
    rstn = 0;
    #1;
    chk("rstreq_ctl", {trap_req_o, stall_o, flush_o}, 0);
    chk("rstreq_epc", trap_epc_o, 0);
    step();
    rstn = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_quiet", {trap_req_o, stall_o, flush_o}, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
